// File: rtl/wah_i2s_tx.sv
// I2S transmitter for the wah output: one handshaked mono sample per frame, sent in both slots.
// Optional build macro WAH_I2S_TX_MUTE_EN: underrun frames send silence instead of the last sample.
module wah_i2s_tx #(
  parameter int unsigned SAMPLE_WIDTH  = 24,
  parameter int unsigned BCLK_HALF_DIV = 10,
  parameter int unsigned SLOT_BITS     = 25
) (
  input  logic                    system_clock,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    frame_start,
  output logic                    underrun
);

  localparam int unsigned DivW = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam int unsigned BitW = $clog2(2 * SLOT_BITS + 1);

  logic [DivW-1:0]         div_q, div_d;
  logic [BitW-1:0]         bit_q, bit_d, bit_nxt, slot;
  logic                    bclk_q, bclk_d;
  logic                    lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic                    frame_start_q, frame_start_d;
  logic                    underrun_q, underrun_d;
  logic                    started_q, started_d;
  logic                    full_q, full_d;
  logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
  logic [SAMPLE_WIDTH-1:0] last_q, last_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic                    div_wrap, fall, load, accept;
  logic [SAMPLE_WIDTH-1:0] fallback;

`ifdef WAH_I2S_TX_MUTE_EN
  assign fallback = '0;
`else
  assign fallback = last_q;
`endif

  always_comb begin
    div_wrap      = (div_q == DivW'(BCLK_HALF_DIV - 1));
    fall          = div_wrap & bclk_q;
    div_d         = div_wrap ? '0 : div_q + 1'b1;
    bclk_d        = div_wrap ? ~bclk_q : bclk_q;

    // The first fall event after reset starts a frame without advancing the bit counter.
    if (!started_q || bit_q == BitW'(2 * SLOT_BITS - 1)) begin
      bit_nxt = '0;
    end else begin
      bit_nxt = bit_q + 1'b1;
    end
    load          = fall & (~started_q | (bit_nxt == '0));
    accept        = sample_valid & ~full_q;
    slot          = (bit_nxt >= BitW'(SLOT_BITS)) ? bit_nxt - BitW'(SLOT_BITS) : bit_nxt;

    bit_d         = bit_q;
    lrclk_d       = lrclk_q;
    sdata_d       = sdata_q;
    shift_d       = shift_q;
    started_d     = started_q;
    frame_start_d = load;
    underrun_d    = underrun_q;
    full_d        = full_q;
    hold_d        = hold_q;
    last_d        = last_q;

    if (accept) begin
      full_d = 1'b1;
      hold_d = sample_in;
    end

    // A transfer landing on an empty load cycle only fills holding for the next frame.
    if (load) begin
      if (full_q) begin
        last_d = hold_q;
        full_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
        last_d     = fallback;
      end
    end

    if (fall) begin
      started_d = 1'b1;
      bit_d     = bit_nxt;
      lrclk_d   = (bit_nxt >= BitW'(SLOT_BITS));
      if (slot == '0) begin
        // last_d holds the frame's sample in both slots, so reload it at each slot start.
        sdata_d = 1'b0;
        shift_d = last_d;
      end else if (slot <= BitW'(SAMPLE_WIDTH)) begin
        sdata_d = shift_q[SAMPLE_WIDTH-1];
        shift_d = {shift_q[SAMPLE_WIDTH-2:0], 1'b0};
      end else begin
        sdata_d = 1'b0;
      end
    end
  end

  always_ff @(posedge system_clock) begin
    if (rst) begin
      div_q         <= '0;
      bit_q         <= '0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      started_q     <= 1'b0;
      full_q        <= 1'b0;
      hold_q        <= '0;
      last_q        <= '0;
      shift_q       <= '0;
    end else begin
      div_q         <= div_d;
      bit_q         <= bit_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      started_q     <= started_d;
      full_q        <= full_d;
      hold_q        <= hold_d;
      last_q        <= last_d;
      shift_q       <= shift_d;
    end
  end

  assign sample_ready = ~full_q;
  assign bclk         = bclk_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_wah_i2s_tx.sv
// Scoreboard bench for wah_i2s_tx: driver queues accepted samples, a monitor decodes frames.
module tb_wah_i2s_tx;
  localparam int W          = 24;
  localparam int HALF       = 10;
  localparam int SLOT       = 25;
  localparam int FRAME      = 2 * SLOT * 2 * HALF;
  localparam int FIRST_LOAD = 2 * HALF;

  logic         system_clock = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sample_in = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready, bclk, lrclk, sdata, frame_start, underrun;

  wah_i2s_tx #(
    .SAMPLE_WIDTH (W),
    .BCLK_HALF_DIV(HALF),
    .SLOT_BITS    (SLOT)
  ) dut (
    .system_clock(system_clock),
    .rst         (rst),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sdata       (sdata),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 system_clock = ~system_clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;  // number of the last rising edge since reset release
  always @(posedge system_clock) cyc <= rst ? 0 : cyc + 1;

  typedef struct {
    logic [W-1:0] val;
    int           acc_edge;
  } acc_t;
  acc_t pend[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] exp_data(input logic [W-1:0] v);
    logic [63:0] r = '0;
    for (int i = 0; i < 2 * SLOT; i++) begin
      int s = i % SLOT;
      if (s >= 1 && s <= W) r[i] = v[W-s];
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_lr();
    logic [63:0] r = '0;
    for (int i = SLOT; i < 2 * SLOT; i++) r[i] = 1'b1;
    return r;
  endfunction

  // ---------------- monitor / reference model ----------------
  logic [W-1:0] last_m = '0;
  logic [W-1:0] cur = '0;
  logic [63:0]  dbits = '0, lbits = '0;
  bit           uflag = 0, active = 0, prev_bclk = 0;
  int           k = 0, nb = 0;
  acc_t         popped;

  always @(negedge system_clock) begin
    if (rst) begin
      pend.delete();
      last_m = '0; uflag = 0; k = 0; active = 0; prev_bclk = 0; nb = 0;
    end else begin
      if (cyc == HALF - 1) check("bclk_before_first_rise", bclk, 0);
      if (cyc == HALF) check("bclk_first_rise", bclk, 1);
      if (bclk && !prev_bclk && active) begin
        dbits[nb] = sdata;
        lbits[nb] = lrclk;
        nb++;
        if (nb == 2 * SLOT) begin
          check("frame_sdata", dbits, exp_data(cur));
          check("frame_lrclk", lbits, exp_lr());
          active = 0;
        end
      end
      prev_bclk = bclk;
      if (frame_start || cyc == FIRST_LOAD + k * FRAME) begin
        check("frame_start_cycle", frame_start ? 64'(cyc) : 64'hFFFF_FFFF,
              64'(FIRST_LOAD + k * FRAME));
        if (active) begin
          checks++; failures++;
          $display("FAIL frame_length: got %0d bits expected %0d", nb, 2 * SLOT);
        end
        k++;
        if (pend.size() > 0 && pend[0].acc_edge < cyc) begin
          popped = pend.pop_front();
          cur = popped.val;
          last_m = cur;
        end else begin
          uflag = 1;
`ifdef WAH_I2S_TX_MUTE_EN
          last_m = '0;
`endif
          cur = last_m;
        end
        check("underrun", underrun, uflag);
        active = 1; nb = 0; dbits = '0; lbits = '0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge system_clock);
    #2;
  endtask

  task automatic send(input logic [W-1:0] v, output int acc);
    int n = 0;
    sample_valid = 1'b1;
    sample_in    = v;
    while (!sample_ready && n < 3 * FRAME) begin
      tick();
      n++;
    end
    if (!sample_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: sample %0h never accepted", v);
      acc = -1;
    end else begin
      acc = cyc + 1;
      pend.push_back('{v, acc});
      tick();
    end
    sample_valid = 1'b0;
    sample_in    = W'($urandom);
  endtask

  task automatic check_reset_outputs();
    check("rst_bclk", bclk, 0);
    check("rst_lrclk", lrclk, 0);
    check("rst_sdata", sdata, 0);
    check("rst_ready", sample_ready, 1);
    check("rst_frame_start", frame_start, 0);
    check("rst_underrun", underrun, 0);
  endtask

  task automatic wait_load_edge();
    int n = 0;
    while ((cyc % FRAME) != FIRST_LOAD && n < 2 * FRAME) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int acc;
    int base;
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;

    // Bit order, then back-to-back samples under backpressure.
    send(24'h800001, acc);
    check("accept_edge_first", acc, 1);
    send(24'h123456, acc);
    check("accept_edge_after_load", acc, FIRST_LOAD + 1);
    check("ready_low_while_full", sample_ready, 0);
    send(24'hABCDEF, acc);
    check("accept_edge_stalled", acc, FIRST_LOAD + FRAME + 1);
    send(24'h7FFFFF, acc);

    // Starve for a couple of frames, then collide with a load edge.
    while (cyc < 4 * FRAME + 100) tick();
    while (((cyc + 1) % FRAME) != FIRST_LOAD) tick();
    check("ready_before_collision", sample_ready, 1);
    sample_valid = 1'b1;
    sample_in    = W'($urandom);
    pend.push_back('{sample_in, cyc + 1});
    tick();
    sample_valid = 1'b0;
    repeat (FRAME + 100) tick();

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 1500)) tick();
      send(W'($urandom), acc);
    end

    // Hold a sample, then reset at bit 30 of the frame.
    repeat (FRAME + 50) tick();
    wait_load_edge();
    base = cyc;
    send(W'($urandom), acc);
    while (cyc < base + 30 * 2 * HALF) tick();
    check("lrclk_mid_frame", lrclk, 1);
    rst = 1'b1;
    tick();
    check_reset_outputs();
    repeat (2) tick();
    rst = 1'b0;
    repeat (FRAME + 100) tick();
    send(W'($urandom), acc);
    repeat (2 * FRAME + 50) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #800000;
    failures++;
    $display("FAIL watchdog: bench did not complete within the time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
